port_scheduler: RTL and testbench

- Packet-level scheduler that shares the single switch-fabric transfer slot among the eight input ports.
- Each input port raises a request with a 4-bit destination address.
- The block picks one requester round-robin and checks that the destination output FIFO has room.
- It then issues a one-cycle grant to the source and a one-cycle push to the destination FIFO.
- It adds full-FIFO backpressure, a bounded wait with skip, and a drop path for illegal addresses.

---
 rtl/router_pkg.sv | 23 ++
 rtl/port_scheduler_if.sv | 35 +++
 rtl/port_scheduler_rr_pick.sv | 39 +++
 rtl/port_scheduler.sv | 133 +++++++++++++
 tb/tb_port_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared defaults, scheduler state encoding and width helper.
// Revision : 1.0
// ============================================================================
package router_pkg;

    localparam int NPORTS_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : port_scheduler_if
// Purpose  : Request/grant bundle between the input ports and the scheduler.
// Revision : 1.0
// ============================================================================
interface port_scheduler_if
    import router_pkg::*;
#(
    parameter int NPORTS = NPORTS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [NPORTS-1:0]        req;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS-1:0]        mask;
    logic [NPORTS-1:0]        fifo_full;
    logic [NPORTS-1:0]        grant;
    logic [NPORTS-1:0]        push;
    logic                     drop;
    logic                     skip;
    logic                     busy;

    modport master (
        output req, addr, mask, fifo_full,
        input  grant, push, drop, skip, busy
    );

    modport slave (
        input  req, addr, mask, fifo_full,
        output grant, push, drop, skip, busy
    );

endinterface
`default_nettype wire

// File: rtl/port_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Rotate-priority encoder: first set bit scanning from ptr upward.
// Revision : 1.0
// ============================================================================
module rr_pick
    import router_pkg::*;
#(
    parameter int NPORTS = NPORTS_DEF,
    parameter int PW     = ptr_width(NPORTS)
) (
    input  logic [NPORTS-1:0] eligible,
    input  logic [PW-1:0]     ptr,
    output logic              found,
    output logic [PW-1:0]     index
);

    logic [NPORTS-1:0] rotated;
    logic [PW:0]       offset;
    logic [PW:0]       sum;

    always_comb begin
        // Bit k of the rotated vector is port (ptr + k) mod NPORTS.
        rotated = NPORTS'({eligible, eligible} >> ptr);
        found   = 1'b0;
        offset  = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = (PW+1)'(k);
            end
        end
        sum   = {1'b0, ptr} + offset;
        index = (sum >= (PW+1)'(NPORTS)) ? PW'(sum - (PW+1)'(NPORTS)) : PW'(sum);
    end

endmodule
`default_nettype wire

// File: rtl/port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : port_scheduler
// Purpose  : Round-robin switch-slot scheduler with FIFO backpressure, bounded
//            wait/skip and drop of illegal destinations.
// Revision : 1.0
// ============================================================================
module port_scheduler
    import router_pkg::*;
#(
    parameter int NPORTS   = NPORTS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    port_scheduler_if.slave bus
);

    localparam int PW = ptr_width(NPORTS);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [1:0]    S_IDLE    = 2'(IDLE);
    localparam logic [1:0]    S_WAIT    = 2'(WAIT);
    localparam logic [1:0]    S_GRANT   = 2'(GRANT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NPORTS - 1);

    logic [1:0]        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     sel;
    logic [ADDR_W-1:0] dest;
    logic              drop_flag;
    logic [CW-1:0]     wait_cnt;
    logic              skip_q;

    logic [ADDR_W-1:0] addr_arr [NPORTS];
    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] cand_hot;
    logic [NPORTS-1:0] dest_hot;
    logic [NPORTS-1:0] grant_vec;
    logic [NPORTS-1:0] push_vec;
    logic [ADDR_W-1:0] cand_addr;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     ptr_after_sel;
    logic              found;
    logic              cand_legal;
    logic              cand_full;
    logic              dest_full;
    logic              sel_live;

    genvar i;
    generate
        for (i = 0; i < NPORTS; i++) begin : g_port
            assign addr_arr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
            assign cand_hot[i]  = (cand_addr == ADDR_W'(i));
            assign dest_hot[i]  = (dest == ADDR_W'(i));
            assign grant_vec[i] = (state == S_GRANT) && (sel == PW'(i));
            assign push_vec[i]  = (state == S_GRANT) && !drop_flag && dest_hot[i];
        end
    endgenerate

    assign eligible = bus.req & ~bus.mask;

    rr_pick #(
        .NPORTS (NPORTS),
        .PW     (PW)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (found),
        .index    (pick)
    );

    // A destination outside the one-hot decode range is an illegal address.
    assign cand_addr     = addr_arr[pick];
    assign cand_legal    = |cand_hot;
    assign cand_full     = |(bus.fifo_full & cand_hot);
    assign dest_full     = |(bus.fifo_full & dest_hot);
    assign sel_live      = bus.req[sel] & ~bus.mask[sel];
    assign ptr_after_sel = (sel == PTR_LAST) ? '0 : sel + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            sel       <= '0;
            dest      <= '0;
            drop_flag <= 1'b0;
            wait_cnt  <= '0;
            skip_q    <= 1'b0;
        end else begin
            skip_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        sel       <= pick;
                        dest      <= cand_addr;
                        drop_flag <= !cand_legal;
                        wait_cnt  <= '0;
                        state     <= (cand_legal && cand_full) ? S_WAIT : S_GRANT;
                    end
                end
                S_WAIT: begin
                    if (!sel_live) begin
                        state <= S_IDLE;
                    end else if (!dest_full) begin
                        state <= S_GRANT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state  <= S_IDLE;
                        skip_q <= 1'b1;
                        ptr    <= ptr_after_sel;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_GRANT: begin
                    ptr   <= ptr_after_sel;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant = grant_vec;
    assign bus.push  = push_vec;
    assign bus.drop  = (state == S_GRANT) && drop_flag;
    assign bus.skip  = skip_q;
    assign bus.busy  = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_scheduler
// Purpose  : Directed and randomized checks of port_scheduler against a
//            cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_port_scheduler;

    localparam int N  = 8;
    localparam int AW = 4;
    localparam int MW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    port_scheduler_if #(.NPORTS(N), .ADDR_W(AW)) bus ();

    port_scheduler #(
        .NPORTS   (N),
        .ADDR_W   (AW),
        .MAX_WAIT (MW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = idle, 1 = waiting on full FIFO, 2 = granting.
    int m_phase, m_ptr, m_sel, m_dest, m_cnt;
    bit m_drop, m_skip;

    logic [N-1:0] e_grant, e_push;
    logic         e_drop, e_skip, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        bus.addr[p*AW +: AW] = a;
    endtask

    task automatic model_step();
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_sel = 0; m_dest = 0; m_cnt = 0;
            m_drop = 0;  m_skip = 0;
            return;
        end
        m_skip = 0;
        case (m_phase)
            0: begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_ptr + k) % N;
                    if (bus.req[p] && !bus.mask[p]) begin
                        m_sel   = p;
                        m_dest  = int'(bus.addr[p*AW +: AW]);
                        m_drop  = (m_dest >= N);
                        m_cnt   = 0;
                        m_phase = (!m_drop && bus.fifo_full[m_dest]) ? 1 : 2;
                        break;
                    end
                end
            end
            1: begin
                if (!bus.req[m_sel] || bus.mask[m_sel]) m_phase = 0;
                else if (!bus.fifo_full[m_dest])       m_phase = 2;
                else if (m_cnt == MW - 1) begin
                    m_phase = 0;
                    m_skip  = 1;
                    m_ptr   = (m_sel + 1) % N;
                end else m_cnt++;
            end
            default: begin
                m_ptr   = (m_sel + 1) % N;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        e_grant = (m_phase == 2) ? (N'(1) << m_sel) : '0;
        e_push  = (m_phase == 2 && !m_drop) ? (N'(1) << m_dest) : '0;
        e_drop  = (m_phase == 2) && m_drop;
        e_skip  = m_skip;
        e_busy  = (m_phase != 0);
        chk("grant", bus.grant, e_grant);
        chk("push",  bus.push,  e_push);
        chk("drop",  bus.drop,  e_drop);
        chk("skip",  bus.skip,  e_skip);
        chk("busy",  bus.busy,  e_busy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        bus.req = '0; bus.mask = '0; bus.addr = '0; bus.fifo_full = '0;
        cycle();
        do_reset();
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_grant", bus.grant, 8'h00);

        // Single request, legal non-full destination.
        bus.req = 8'h01; set_addr(0, 4'd3);
        cycle();
        chk("t1_grant", bus.grant, 8'h01);
        chk("t1_push",  bus.push,  8'h08);
        chk("t1_busy",  bus.busy,  1'b1);
        bus.req = '0;
        cycle();
        chk("t1_idle_busy", bus.busy, 1'b0);

        // All ports requesting: strict rotation at 2-cycle spacing.
        do_reset();
        bus.req = 8'hFF;
        for (int p = 0; p < N; p++) set_addr(p, AW'(p));
        for (int g = 0; g < 9; g++) begin
            cycle();
            chk("t2_grant", bus.grant, N'(1) << (g % N));
            bus.req[g % N] = 1'b0;
            cycle();
            chk("t2_gap", bus.grant, 8'h00);
            bus.req[g % N] = 1'b1;
        end
        bus.req = '0;

        // Five cycles of backpressure, then grant.
        do_reset();
        bus.req = 8'h04; set_addr(2, 4'd5); bus.fifo_full = 8'h20;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t3_wait_busy", bus.busy, 1'b1);
        end
        bus.fifo_full = '0;
        cycle();
        chk("t3_grant", bus.grant, 8'h04);
        chk("t3_push",  bus.push,  8'h20);
        bus.req = '0;
        cycle();

        // Stuck-full destination: skip after MAX_WAIT cycles, next port served.
        do_reset();
        bus.req = 8'h06; set_addr(1, 4'd5); set_addr(2, 4'd0); bus.fifo_full = 8'h20;
        for (int c = 0; c < MW; c++) begin
            cycle();
            chk("t4_wait_skip", bus.skip, 1'b0);
            chk("t4_wait_busy", bus.busy, 1'b1);
        end
        cycle();
        chk("t4_skip", bus.skip, 1'b1);
        chk("t4_skip_busy", bus.busy, 1'b0);
        cycle();
        chk("t4_grant", bus.grant, 8'h04);
        chk("t4_push",  bus.push,  8'h01);
        bus.req = '0; bus.fifo_full = '0;
        cycle();

        // Illegal destination is dropped.
        do_reset();
        bus.req = 8'h10; set_addr(4, 4'hA);
        cycle();
        chk("t5_grant", bus.grant, 8'h10);
        chk("t5_drop",  bus.drop,  1'b1);
        chk("t5_push",  bus.push,  8'h00);
        bus.req = '0;
        cycle();

        // Reset while waiting, then pointer back at port 0.
        do_reset();
        bus.req = 8'h08; set_addr(3, 4'd6); bus.fifo_full = 8'h40;
        cycle();
        cycle();
        chk("t6_in_wait", bus.busy, 1'b1);
        reset = 1'b1;
        cycle();
        chk("t6_rst_grant", bus.grant, 8'h00);
        chk("t6_rst_push",  bus.push,  8'h00);
        chk("t6_rst_busy",  bus.busy,  1'b0);
        reset = 1'b0;
        bus.fifo_full = '0; bus.req = 8'h81; set_addr(0, 4'd1); set_addr(7, 4'd2);
        cycle();
        chk("t6_ptr0_grant", bus.grant, 8'h01);
        bus.req = '0;
        cycle();

        // Masked requester is never granted.
        bus.mask = 8'h01; bus.req = 8'h01;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("t6_mask_grant", bus.grant, 8'h00);
        end
        bus.mask = '0; bus.req = '0;
        cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (e_grant[p]) bus.req[p] = 1'b0;
                else if (!bus.req[p] && $urandom_range(0, 99) < 30) begin
                    bus.req[p] = 1'b1;
                    set_addr(p, AW'($urandom_range(0, 9)));
                end else if (bus.req[p] && $urandom_range(0, 99) < 2) bus.req[p] = 1'b0;
            end
            if ($urandom_range(0, 99) < 3) set_addr(int'($urandom_range(0, N-1)), AW'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) < 5) bus.mask = N'($urandom & $urandom & $urandom);
            bus.fifo_full = bus.fifo_full ^ N'($urandom & $urandom & $urandom);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
